prbs_ber_ctrl: RTL and testbench

Bit-error-rate test controller for the PRBS7 link-test path. It sequences a transmit PRBS7 generator (x^7+x^6+1) and aligns a receive-side reference LFSR to the looped-back stream. It then counts compared bits and bit errors, and detects loss of lock. It sits between the link-test register block (start/abort/results) and the serial TX/RX bit interfaces.

---
 rtl/prbs_ber_ctrl_pkg.sv | 23 ++
 rtl/prbs7_lfsr.sv | 29 ++
 rtl/prbs_ber_ctrl.sv | 177 +++++++++++++++++
 tb/tb_prbs_ber_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_ber_ctrl_pkg.sv
// Shared definitions for the PRBS7 bit-error-rate controller.
// Covers controller states, the PRBS7 seed and taps, and the widths of the result fields.
package prbs_ber_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SYNC,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [6:0] PRBS_SEED    = 7'h7F;
    localparam int         TAP_HI       = 6;
    localparam int         TAP_LO       = 5;
    localparam int         RESULT_CNT_W = 16;

    // Feedback for x^7 + x^6 + 1.
    function automatic logic prbs7_fb(input logic [6:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS7 shift register with a synchronous load and a choice of shift-in bit (feedback or external).
// Latency: the new state appears one cycle after enable. There is no backpressure; the owner gates enable.
module prbs7_lfsr
    import prbs_ber_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] load_value,
    input  logic       enable,
    input  logic       use_ext,
    input  logic       ext_bit,
    output logic [6:0] value,
    output logic       feedback
);

    assign feedback = prbs7_fb(value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= PRBS_SEED;
        end else if (load) begin
            value <= load_value;
        end else if (enable) begin
            value <= {value[5:0], use_ext ? ext_bit : feedback};
        end
    end

endmodule

// File: rtl/prbs_ber_ctrl.sv
// PRBS7 BER test controller: it transmits PRBS7, locks a reference to the looped-back stream, and counts bits and errors.
// Latency: one cycle per state step. TX advances only on tx_ready, and RX is consumed only when rx_valid is high.
module prbs_ber_ctrl
    import prbs_ber_ctrl_pkg::*;
#(
    parameter int N            = 7,
    parameter int CNT_W        = RESULT_CNT_W,
    parameter int TEST_BITS    = 1024,
    parameter int LOCK_BITS    = 32,
    parameter int SYNC_TIMEOUT = 1023,
    parameter int LOL_WIN      = 64,
    parameter int LOL_ERRS     = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             tx_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    input  logic             rx_bit,
    input  logic             rx_valid,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             sync_fail,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_BITS + 1);
    localparam int TW = $clog2(SYNC_TIMEOUT + 1);
    localparam int WW = $clog2(LOL_WIN + 1);

    state_t           state, state_nx;
    logic [N-1:0]     tx_value, rx_value;
    logic             tx_fb, rx_fb;
    logic             in_sync, in_run, rx_step, rx_err;
    logic [MW-1:0]    match_cnt, match_nx;
    logic [TW-1:0]    tmo_cnt, tmo_nx;
    logic [WW-1:0]    win_bits, win_nx, win_errs, werr_nx;
    logic [CNT_W-1:0] bit_nx;
    logic             lock_hit, tmo_hit, test_hit, lol_hit;
    logic             unused_tx;

    assign in_sync  = (state == ST_SYNC);
    assign in_run   = (state == ST_RUN);
    assign rx_step  = rx_valid && (in_sync || in_run) && !abort;
    assign rx_err   = rx_bit ^ rx_fb;

    // An all-zero reference predicts zeros forever, so it never counts toward lock.
    assign match_nx = (!rx_err && (rx_value != '0)) ? match_cnt + MW'(1) : '0;
    assign tmo_nx   = tmo_cnt + TW'(1);
    assign bit_nx   = bit_cnt + CNT_W'(1);
    assign win_nx   = win_bits + WW'(1);
    assign werr_nx  = win_errs + WW'(rx_err);

    assign lock_hit = (match_nx == MW'(LOCK_BITS));
    assign tmo_hit  = (tmo_nx == TW'(SYNC_TIMEOUT));
    assign test_hit = (bit_nx == CNT_W'(TEST_BITS));
    assign lol_hit  = (werr_nx >= WW'(LOL_ERRS));

    assign busy     = (state != ST_IDLE);
    assign locked   = in_run;
    assign done     = (state == ST_DONE);
    assign tx_valid = in_sync || in_run;
    assign tx_bit   = tx_valid & tx_value[N-1];

    assign unused_tx = ^{tx_value[N-2:0], tx_fb};

    prbs7_lfsr u_tx_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state == ST_SEED),
        .load_value (PRBS_SEED),
        .enable     (tx_valid && tx_ready),
        .use_ext    (1'b0),
        .ext_bit    (1'b0),
        .value      (tx_value),
        .feedback   (tx_fb)
    );

    // The RX reference loads the line while hunting, then free-runs once locked.
    prbs7_lfsr u_rx_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state == ST_SEED),
        .load_value ('0),
        .enable     (rx_step),
        .use_ext    (in_sync),
        .ext_bit    (rx_bit),
        .value      (rx_value),
        .feedback   (rx_fb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_SEED;
            ST_SEED: state_nx = ST_SYNC;
            ST_SYNC: begin
                if (rx_valid) begin
                    if (lock_hit)     state_nx = ST_RUN;
                    else if (tmo_hit) state_nx = ST_DONE;
                end
            end
            ST_RUN: begin
                if (rx_valid) begin
                    if (test_hit)     state_nx = ST_DONE;
                    else if (lol_hit) state_nx = ST_SYNC;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (abort) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            tmo_cnt   <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            sync_fail <= 1'b0;
        end else if (!abort) begin
            case (state)
                ST_SEED: begin
                    match_cnt <= '0;
                    tmo_cnt   <= '0;
                    win_bits  <= '0;
                    win_errs  <= '0;
                    bit_cnt   <= '0;
                    err_cnt   <= '0;
                    sync_fail <= 1'b0;
                end
                ST_SYNC: begin
                    win_bits <= '0;
                    win_errs <= '0;
                    if (rx_valid) begin
                        match_cnt <= match_nx;
                        tmo_cnt   <= tmo_nx;
                        if (!lock_hit && tmo_hit) sync_fail <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Cleared here so a loss of lock re-enters SYNC with a fresh hunt.
                    match_cnt <= '0;
                    tmo_cnt   <= '0;
                    if (rx_valid) begin
                        bit_cnt <= bit_nx;
                        if (rx_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
                        if (win_nx == WW'(LOL_WIN)) begin
                            win_bits <= '0;
                            win_errs <= '0;
                        end else begin
                            win_bits <= win_nx;
                            win_errs <= werr_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Bench for prbs_ber_ctrl: a table of loopback scenarios plus abort and async-reset sequences,
// with every cycle checked against a sequence-level reference model.
module tb_prbs_ber_ctrl;

    localparam int TEST_BITS    = 256;
    localparam int LOCK_BITS    = 32;
    localparam int SYNC_TIMEOUT = 1023;
    localparam int LOL_WIN      = 64;
    localparam int LOL_ERRS     = 8;
    localparam int LIMIT        = 6000;

    localparam int MD_LOOP  = 0;
    localparam int MD_FLIP2 = 1;
    localparam int MD_STUCK = 2;
    localparam int MD_BURST = 3;
    localparam int MD_NOISE = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, tx_ready, rx_bit, rx_valid;
    logic        tx_bit, tx_valid, busy, locked, done, sync_fail;
    logic [15:0] bit_cnt, err_cnt;

    always #5 clk = ~clk;

    prbs_ber_ctrl #(
        .TEST_BITS    (TEST_BITS),
        .LOCK_BITS    (LOCK_BITS),
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .LOL_WIN      (LOL_WIN),
        .LOL_ERRS     (LOL_ERRS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .tx_ready  (tx_ready),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .sync_fail (sync_fail),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the expected stream comes from the recurrence o[n] = o[n-7] ^ o[n-6].
    typedef enum int {M_IDLE, M_SEED, M_SYNC, M_RUN, M_DONE} mstate_e;
    mstate_e m_st;
    bit      prbs_seq[127];
    bit      rxq[$];
    int      tx_idx, m_match, m_tmo, m_bits, m_errs, m_wbits, m_werrs;
    bit      m_sfail;

    task automatic reset_model();
        m_st = M_IDLE; tx_idx = 0; m_match = 0; m_tmo = 0;
        m_bits = 0; m_errs = 0; m_wbits = 0; m_werrs = 0; m_sfail = 0;
        rxq = '{0, 0, 0, 0, 0, 0, 0};
    endtask

    task automatic model_step(input bit st, input bit ab, input bit tr, input bit rv, input bit rb);
        bit pred, nz, e;
        if (ab) begin
            m_st = M_IDLE;
            return;
        end
        pred = rxq[0] ^ rxq[1];
        nz = 0;
        foreach (rxq[i]) nz |= rxq[i];
        case (m_st)
            M_IDLE: if (st) m_st = M_SEED;
            M_SEED: begin
                tx_idx = 0; m_bits = 0; m_errs = 0; m_sfail = 0;
                m_match = 0; m_tmo = 0; m_wbits = 0; m_werrs = 0;
                rxq = '{0, 0, 0, 0, 0, 0, 0};
                m_st = M_SYNC;
            end
            M_SYNC: begin
                if (tr) tx_idx++;
                if (rv) begin
                    rxq.push_back(rb);
                    void'(rxq.pop_front());
                    m_tmo++;
                    if (rb == pred && nz) m_match++; else m_match = 0;
                    if (m_match == LOCK_BITS) begin
                        m_st = M_RUN; m_wbits = 0; m_werrs = 0;
                    end else if (m_tmo == SYNC_TIMEOUT) begin
                        m_st = M_DONE; m_sfail = 1;
                    end
                end
            end
            M_RUN: begin
                if (tr) tx_idx++;
                if (rv) begin
                    rxq.push_back(pred);
                    void'(rxq.pop_front());
                    e = (rb != pred);
                    m_bits++;
                    if (e && m_errs < 65535) m_errs++;
                    m_wbits++;
                    m_werrs += int'(e);
                    if (m_bits == TEST_BITS) m_st = M_DONE;
                    else if (m_werrs >= LOL_ERRS) begin
                        m_st = M_SYNC; m_match = 0; m_tmo = 0;
                    end
                    if (m_wbits == LOL_WIN || m_st != M_RUN) begin
                        m_wbits = 0; m_werrs = 0;
                    end
                end
            end
            M_DONE: m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase
    endtask

    // Loopback channel and scenario state
    bit         d1v, d1b, d2v, d2b, prev_locked;
    int         mode, burst_left, lock_rises, done_cnt, ntx;
    bit         rand_ready, rand_start;
    logic [7:0] first8;

    task automatic cycle(input bit st, input bit ab);
        bit fl, mtv, mtb;
        logic [37:0] act, exp;
        start = st;
        abort = ab;
        if (rand_start && m_st != M_IDLE && $urandom_range(0, 99) == 0) start = 1'b1;
        tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mode == MD_STUCK) begin
            rx_valid = 1'b1;
            rx_bit   = 1'b0;
        end else begin
            fl = 0;
            if (d2v) begin
                case (mode)
                    MD_FLIP2: fl = (m_st == M_RUN) && (m_bits + 1 == 100 || m_bits + 1 == 200);
                    MD_BURST: begin
                        if (m_st == M_RUN && m_bits + 1 == 50) burst_left = 10;
                        if (burst_left > 0) begin
                            fl = 1;
                            burst_left--;
                        end
                    end
                    MD_NOISE: fl = ($urandom_range(0, 63) == 0);
                    default: fl = 0;
                endcase
            end
            rx_valid = d2v;
            rx_bit   = d2b ^ fl;
        end
        d2v = d1v; d2b = d1b;
        d1v = tx_valid && tx_ready; d1b = tx_bit;
        if (tx_valid && tx_ready && ntx < 8) begin
            first8 = {first8[6:0], tx_bit};
            ntx++;
        end
        @(posedge clk);
        model_step(start, abort, tx_ready, rx_valid, rx_bit);
        @(negedge clk);
        mtv = (m_st == M_SYNC || m_st == M_RUN);
        mtb = mtv ? prbs_seq[tx_idx % 127] : 1'b0;
        act = {busy, locked, done, tx_valid, tx_bit, sync_fail, bit_cnt, err_cnt};
        exp = {m_st != M_IDLE, m_st == M_RUN, m_st == M_DONE, mtv, mtb, m_sfail,
               16'(m_bits), 16'(m_errs)};
        check("outputs", act, exp);
        if (locked && !prev_locked) lock_rises++;
        prev_locked = locked;
        if (done) done_cnt++;
    endtask

    typedef struct {
        int mode;
        bit rnd;
        int exp_bits;
        int exp_errs;
        bit err_ge;
        int exp_sfail;
        int exp_locks;
    } vec_t;
    vec_t vecs[6];

    task automatic clear_scen(input int md, input bit rnd);
        mode = md; rand_ready = rnd; rand_start = rnd;
        burst_left = 0; lock_rises = 0; done_cnt = 0; ntx = 0; first8 = '0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int n;
        v = vecs[i];
        clear_scen(v.mode, v.rnd);
        cycle(1, 0);
        n = 0;
        while (m_st != M_IDLE && n < LIMIT) begin
            cycle(0, 0);
            n++;
        end
        check($sformatf("v%0d_in_time", i), n < LIMIT, 1);
        check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
        check($sformatf("v%0d_first_tx", i), first8, 8'hFE);
        if (v.exp_bits >= 0) check($sformatf("v%0d_bit_cnt", i), bit_cnt, v.exp_bits);
        if (v.exp_errs >= 0) begin
            if (v.err_ge) check($sformatf("v%0d_err_cnt_min", i), err_cnt >= v.exp_errs, 1);
            else          check($sformatf("v%0d_err_cnt", i), err_cnt, v.exp_errs);
        end
        if (v.exp_sfail >= 0) check($sformatf("v%0d_sync_fail", i), sync_fail, v.exp_sfail);
        if (v.exp_locks >= 0) check($sformatf("v%0d_lock_rises", i), lock_rises, v.exp_locks);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 7; k++) prbs_seq[k] = 1;
        for (int k = 7; k < 127; k++) prbs_seq[k] = prbs_seq[k-7] ^ prbs_seq[k-6];

        vecs[0] = '{MD_LOOP,  0, 256,  0, 0,  0,  1};
        vecs[1] = '{MD_FLIP2, 0, 256,  2, 0,  0,  1};
        vecs[2] = '{MD_STUCK, 0,   0,  0, 0,  1,  0};
        vecs[3] = '{MD_BURST, 0, 256,  8, 1,  0,  2};
        vecs[4] = '{MD_LOOP,  1, 256,  0, 0,  0,  1};
        vecs[5] = '{MD_NOISE, 1,  -1, -1, 0, -1, -1};

        rst_n = 0; start = 0; abort = 0; tx_ready = 0; rx_bit = 0; rx_valid = 0;
        reset_model();
        clear_scen(MD_LOOP, 0);
        d1v = 0; d1b = 0; d2v = 0; d2b = 0; prev_locked = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, locked, done, tx_valid, tx_bit, sync_fail, bit_cnt, err_cnt}, 0);
        check("reset_tx_lfsr", dut.u_tx_lfsr.value, 7'h7F);
        check("reset_rx_lfsr", dut.u_rx_lfsr.value, 7'h7F);
        rst_n = 1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Abort at RUN bit 30
        clear_scen(MD_LOOP, 0);
        cycle(1, 0);
        n = 0;
        while (!(m_st == M_RUN && m_bits == 30) && n < LIMIT) begin
            cycle(0, 0);
            n++;
        end
        check("abort_reach_bit30", n < LIMIT, 1);
        cycle(0, 1);
        check("abort_busy", busy, 0);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_bit_cnt", bit_cnt, 30);
        repeat (3) cycle(0, 0);
        check("abort_bit_cnt_hold", bit_cnt, 30);
        check("abort_no_done", done_cnt, 0);
        cycle(1, 0);
        cycle(0, 0);
        check("restart_bit_cnt", bit_cnt, 0);
        check("restart_busy", busy, 1);
        n = 0;
        while (m_st != M_IDLE && n < LIMIT) begin
            cycle(0, 0);
            n++;
        end
        check("restart_bit_cnt_final", bit_cnt, TEST_BITS);

        // Async reset mid-RUN, between clock edges
        clear_scen(MD_LOOP, 0);
        cycle(1, 0);
        n = 0;
        while (!(m_st == M_RUN && m_bits >= 100) && n < LIMIT) begin
            cycle(0, 0);
            n++;
        end
        check("rst_reach_run", n < LIMIT, 1);
        #2 rst_n = 0;
        #1;
        check("arst_outputs", {busy, locked, done, tx_valid, tx_bit, sync_fail, bit_cnt, err_cnt}, 0);
        check("arst_tx_lfsr", dut.u_tx_lfsr.value, 7'h7F);
        check("arst_rx_lfsr", dut.u_rx_lfsr.value, 7'h7F);
        reset_model();
        d1v = 0; d2v = 0; prev_locked = 0;
        @(negedge clk);
        rst_n = 1;
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
